// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and sizing helper for the sequential binary-to-7-segment converter.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Decimal digits needed to hold any WIDTH-bit unsigned value.
    function automatic int idig_f(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_digit_to_seg.sv
// One BCD digit to an active-low {g,f,e,d,c,b,a} segment code; blank or non-decimal input gives all segments off.
module bcd_digit_to_seg
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bin_to_7seg_seq.sv
// Iterative (shift-and-add-3) binary-to-BCD converter driving DIGITS active-low 7-segment codes over valid/ready.
// Optional build macro LEADING_ZERO_BLANK_EN blanks non-overflow high-order zero digits.
module bin_to_7seg_seq
    import seg7_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      number,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7*DIGITS-1:0]   code,
    output logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int IDIG  = idig_f(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state;
    state_t               state_nxt;
    logic [4*IDIG-1:0]    bcd;
    logic [4*IDIG-1:0]    bcd_adj;
    logic [4*IDIG:0]      bcd_wide;
    logic [4*IDIG-1:0]    bcd_shift;
    logic                 unused_bcd_msb;
    logic [WIDTH-1:0]     sreg;
    logic [CNT_W-1:0]     cnt;
    logic                 last_shift;
    logic [3:0]           disp_digit [DIGITS];
    logic [DIGITS-1:0]    blank;
    logic [7*DIGITS-1:0]  seg_raw;
    logic [7*DIGITS-1:0]  code_nxt;
    logic                 ovf_nxt;

    assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Add-3 correction on every digit that would exceed 9 after doubling.
    for (genvar g = 0; g < IDIG; g++) begin : g_adj
        assign bcd_adj[4*g +: 4] = (bcd[4*g +: 4] >= 4'd5) ? bcd[4*g +: 4] + 4'd3
                                                           : bcd[4*g +: 4];
    end

    assign bcd_wide       = {bcd_adj, sreg[WIDTH-1]};
    assign bcd_shift      = bcd_wide[4*IDIG-1:0];
    assign unused_bcd_msb = bcd_wide[4*IDIG];

    if (IDIG > DIGITS) begin : g_ovf
        assign ovf_nxt = |bcd_shift[4*IDIG-1:4*DIGITS];
    end else begin : g_no_ovf
        assign ovf_nxt = 1'b0;
    end

    // Displayed digits above the converter's decimal range read as zero.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        if (g < IDIG) begin : g_real
            assign disp_digit[g] = bcd_shift[4*g +: 4];
        end else begin : g_pad
            assign disp_digit[g] = 4'd0;
        end

        bcd_digit_to_seg u_seg (
            .bcd   (disp_digit[g]),
            .blank (blank[g]),
            .seg   (seg_raw[7*g +: 7])
        );
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;

    // Blank every digit whose own value and all higher values are zero; the ones digit always shows.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_digit[i] == 4'd0);
            blank[i] = zero_run && (i != 0);
        end
    end
`else
    assign blank = '0;
`endif

    assign code_nxt = ovf_nxt ? {DIGITS{SEG_DASH}} : seg_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg     <= '0;
            bcd      <= '0;
            cnt      <= '0;
            code     <= {DIGITS{SEG_BLANK}};
            overflow <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                sreg <= number;
                bcd  <= '0;
                cnt  <= CNT_W'(WIDTH);
            end else if (state == SHIFT) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
                bcd  <= bcd_shift;
                cnt  <= cnt - CNT_W'(1);
                // The final shift's result is encoded straight into the output register.
                if (last_shift) begin
                    code     <= code_nxt;
                    overflow <= ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_7seg_seq.sv
// Bench for bin_to_7seg_seq: a 4-digit and a 2-digit instance share stimulus and are checked against a decimal model.
module tb_bin_to_7seg_seq;

    localparam int W = 8;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  number;
    logic          in_valid;
    logic          out_ready;

    logic          in_ready_a, ovf_a, ovld_a;
    logic [27:0]   code_a;
    logic          in_ready_b, ovf_b, ovld_b;
    logic [13:0]   code_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin_to_7seg_seq #(.WIDTH(W), .DIGITS(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .number(number), .in_valid(in_valid),
        .in_ready(in_ready_a), .code(code_a), .overflow(ovf_a),
        .out_valid(ovld_a), .out_ready(out_ready)
    );

    bin_to_7seg_seq #(.WIDTH(W), .DIGITS(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .number(number), .in_valid(in_valid),
        .in_ready(in_ready_b), .code(code_b), .overflow(ovf_b),
        .out_valid(ovld_b), .out_ready(out_ready)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic bit model_ovf(input int unsigned v, input int nd);
        int unsigned lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        return v >= lim;
    endfunction

    // Expected display as decimal digits of v, ones digit in the low 7 bits, unused high bits all ones.
    function automatic logic [27:0] model_code(input int unsigned v, input int nd);
        logic [27:0] r;
        int unsigned p;
        int top;
        int d;
        r = '1;
        p = 1;
        top = 0;
        for (int i = 0; i < nd; i++) begin
            d = (v / p) % 10;
            if (d != 0) top = i;
            p = p * 10;
        end
        p = 1;
        for (int i = 0; i < nd; i++) begin
            d = (v / p) % 10;
            if (model_ovf(v, nd))      r[7*i +: 7] = 7'b0111111;
            else if (LZB && i > top)   r[7*i +: 7] = 7'b1111111;
            else                       r[7*i +: 7] = seg_of(d);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; number = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (code_a !== 28'hFFFFFFF) begin n_err++; $display("FAIL reset_code_a got %h want fffffff", code_a); end
        n_cmp++; if (code_b !== 14'h3FFF) begin n_err++; $display("FAIL reset_code_b got %h want 3fff", code_b); end
        n_cmp++; if (ovld_a !== 1'b0 || ovf_a !== 1'b0) begin n_err++; $display("FAIL reset_flags got vld=%b ovf=%b want 0 0", ovld_a, ovf_a); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b%b want 11", in_ready_a, in_ready_b); end
    endtask

    task automatic test_conversions();
        int unsigned vals[$];
        vals = '{255, 0, 99, 100, 37, 1, 10, 200, 9, 128};
        repeat (16) vals.push_back($urandom_range(0, 255));
        foreach (vals[k]) begin
            int unsigned v;
            int lat;
            logic [27:0] e4, e2;
            v = vals[k];
            e4 = model_code(v, 4);
            e2 = model_code(v, 2);
            @(negedge clk); number = W'(v); in_valid = 1'b1; out_ready = 1'b0;
            n_cmp++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin n_err++; $display("FAIL conv_in_ready v=%0d got %b%b want 11", v, in_ready_a, in_ready_b); end
            @(posedge clk); #1; in_valid = 1'b0;
            lat = 0;
            while (ovld_a !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
            n_cmp++; if (lat != W) begin n_err++; $display("FAIL conv_latency v=%0d got %0d want %0d", v, lat, W); end
            n_cmp++; if (ovld_b !== 1'b1) begin n_err++; $display("FAIL conv_valid_b v=%0d got %b want 1", v, ovld_b); end
            n_cmp++; if (code_a !== e4) begin n_err++; $display("FAIL conv_code4 v=%0d got %h want %h", v, code_a, e4); end
            n_cmp++; if (code_b !== e2[13:0]) begin n_err++; $display("FAIL conv_code2 v=%0d got %h want %h", v, code_b, e2[13:0]); end
            n_cmp++; if (ovf_a !== model_ovf(v, 4)) begin n_err++; $display("FAIL conv_ovf4 v=%0d got %b want %b", v, ovf_a, model_ovf(v, 4)); end
            n_cmp++; if (ovf_b !== model_ovf(v, 2)) begin n_err++; $display("FAIL conv_ovf2 v=%0d got %b want %b", v, ovf_b, model_ovf(v, 2)); end
            n_cmp++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL conv_busy v=%0d got %b want 0", v, in_ready_a); end
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
            n_cmp++; if (ovld_a !== 1'b0 || in_ready_a !== 1'b1) begin n_err++; $display("FAIL conv_exit v=%0d got vld=%b rdy=%b want 0 1", v, ovld_a, in_ready_a); end
            n_cmp++; if (code_a !== e4) begin n_err++; $display("FAIL conv_code_kept v=%0d got %h want %h", v, code_a, e4); end
        end
    endtask

    task automatic test_backpressure();
        int unsigned v;
        int lat;
        logic [27:0] e4;
        v = 173;
        e4 = model_code(v, 4);
        @(negedge clk); number = W'(v); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        lat = 0;
        while (ovld_a !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (ovld_a !== 1'b1) begin n_err++; $display("FAIL bp_timeout got vld=%b want 1", ovld_a); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); in_valid = (c % 2 == 0); number = W'($urandom_range(0, 255));
            @(posedge clk); #1;
            n_cmp++; if (ovld_a !== 1'b1 || in_ready_a !== 1'b0) begin n_err++; $display("FAIL bp_hold c=%0d got vld=%b rdy=%b want 1 0", c, ovld_a, in_ready_a); end
            n_cmp++; if (code_a !== e4 || ovf_a !== 1'b0) begin n_err++; $display("FAIL bp_code c=%0d got %h ovf=%b want %h 0", c, code_a, ovf_a, e4); end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        n_cmp++; if (ovld_a !== 1'b0 || in_ready_a !== 1'b1) begin n_err++; $display("FAIL bp_consume got vld=%b rdy=%b want 0 1", ovld_a, in_ready_a); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready_a !== 1'b1 || code_a !== e4) begin n_err++; $display("FAIL bp_no_accept got rdy=%b code=%h want 1 %h", in_ready_a, code_a, e4); end
    endtask

    task automatic test_back_to_back();
        int unsigned q[$];
        int unsigned v;
        int last;
        int n_acc;
        logic [27:0] e4;
        last = -1;
        n_acc = 0;
        @(negedge clk); in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 45) in_valid = 1'b0;
            if (ovld_a === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL b2b_extra got result %h want none", code_a);
                end else begin
                    v = q.pop_front();
                    e4 = model_code(v, 4);
                    n_cmp++; if (code_a !== e4) begin n_err++; $display("FAIL b2b_code v=%0d got %h want %h", v, code_a, e4); end
                end
            end
            if (in_ready_a === 1'b1 && in_valid) begin
                if (last >= 0) begin
                    n_cmp++; if (cyc - last != W + 2) begin n_err++; $display("FAIL b2b_period got %0d want %0d", cyc - last, W + 2); end
                end
                last = cyc;
                n_acc++;
                v = $urandom_range(0, 255);
                number = W'(v);
                q.push_back(v);
            end
        end
        out_ready = 1'b0;
        n_cmp++; if (q.size() != 0 || n_acc < 4) begin n_err++; $display("FAIL b2b_drain got pending=%0d accepted=%0d want 0 >=4", q.size(), n_acc); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [27:0] e4;
        @(negedge clk); number = W'(200); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2; reset_n = 1'b0; #1;
        n_cmp++; if (code_a !== 28'hFFFFFFF || code_b !== 14'h3FFF) begin n_err++; $display("FAIL mid_reset_code got %h %h want fffffff 3fff", code_a, code_b); end
        n_cmp++; if (ovld_a !== 1'b0 || ovf_a !== 1'b0 || ovf_b !== 1'b0) begin n_err++; $display("FAIL mid_reset_flags got vld=%b ovf=%b%b want 0 00", ovld_a, ovf_a, ovf_b); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready got %b want 1", in_ready_a); end
        e4 = model_code(37, 4);
        @(negedge clk); number = W'(37); in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        lat = 0;
        while (ovld_a !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat != W) begin n_err++; $display("FAIL mid_after_latency got %0d want %0d", lat, W); end
        n_cmp++; if (code_a !== e4) begin n_err++; $display("FAIL mid_after_code got %h want %h", code_a, e4); end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_conversions();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
